// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer_pkg
//  Description : Shared opcode constants, sequencer state encoding and
//                execute-phase length for the instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

    // Opcode field (rom_data[7:5])
    localparam logic [2:0] OP_ALU_A    = 3'b000;
    localparam logic [2:0] OP_ALU_B    = 3'b001;
    localparam logic [2:0] OP_MEM_LD   = 3'b010;
    localparam logic [2:0] OP_MEM_ST   = 3'b011;
    localparam logic [2:0] OP_HALT     = 3'b100;
    localparam logic [2:0] OP_JUMP     = 3'b101;
    localparam logic [2:0] OP_PORT_IN  = 3'b110;
    localparam logic [2:0] OP_PORT_OUT = 3'b111;

    // Length of the control unit's execute cycle
    localparam int EXEC_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } seq_state_e;

    function automatic logic state_is_busy(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_step_edge.sv
`default_nettype none
// ============================================================================
//  Module      : step_edge
//  Description : Registers the step request and produces a one-cycle pulse
//                on its rising edge.
//  Ports       : clk, clear_n (sync active-low), step (level in),
//                step_rise (one-cycle pulse out)
//  Revision    : 1.0 - initial release
// ============================================================================
module step_edge (
    input  logic clk,
    input  logic clear_n,
    input  logic step,
    output logic step_rise
);

    logic step_d;
    logic step_q;

    always_comb begin
        step_d = step;
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_rise = step & ~step_q;

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Fetch / decode / execute sequencer for a small program ROM.
//                Presents each executed opcode to the control unit for a
//                fixed three-cycle execute window.
//  Ports       : clk, clear_n (sync active-low), run, step,
//                pc_addr/rom_req/rom_ack/rom_data (program memory),
//                instruction/operand/ctl_clear (control unit),
//                busy/halted/fault/pc_wrap (status)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W          = 5,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic            run,
    input  logic            step,
    output logic [PC_W-1:0] pc_addr,
    output logic            rom_req,
    input  logic            rom_ack,
    input  logic [7:0]      rom_data,
    output logic [2:0]      instruction,
    output logic [4:0]      operand,
    output logic            ctl_clear,
    output logic            busy,
    output logic            halted,
    output logic            fault,
    output logic            pc_wrap
);

    localparam int                WAIT_W     = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(FETCH_TIMEOUT - 1);
    localparam logic [1:0]        PHASE_LAST = 2'(EXEC_CYCLES - 1);
    localparam logic [PC_W-1:0]   PC_MAX     = '1;

    seq_state_e        state_d, state_q;
    logic [PC_W-1:0]   pc_d, pc_q;
    logic [7:0]        ir_d, ir_q;
    logic [1:0]        phase_d, phase_q;
    logic [WAIT_W-1:0] wait_d, wait_q;
    logic              fault_d, fault_q;
    logic              wrap_d, wrap_q;
    logic              rom_req_d, rom_req_q;
    logic              busy_d, busy_q;
    logic              halted_d, halted_q;
    logic              ctl_clear_d, ctl_clear_q;
    logic [2:0]        instruction_d, instruction_q;
    logic [4:0]        operand_d, operand_q;

    logic              step_rise;
    logic [PC_W-1:0]   jump_target;

    step_edge u_step_edge (
        .clk       (clk),
        .clear_n   (clear_n),
        .step      (step),
        .step_rise (step_rise)
    );

    // Jump operand is 5 bits wide; fit it to the PC width.
    if (PC_W > 5) begin : g_jump_zext
        assign jump_target = {{(PC_W-5){1'b0}}, ir_q[4:0]};
    end else begin : g_jump_trunc
        assign jump_target = ir_q[PC_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // run has priority; a coincident step edge needs no handling
                if (run || step_rise) begin
                    state_d = ST_FETCH;
                    wait_d  = '0;
                end
            end
            ST_FETCH: begin
                if (rom_ack) begin
                    ir_d    = rom_data;
                    wait_d  = '0;
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                case (ir_q[7:5])
                    OP_HALT: state_d = ST_HALT;
                    OP_JUMP: begin
                        pc_d    = jump_target;
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end
                    default: begin
                        phase_d = '0;
                        state_d = ST_EXEC;
                    end
                endcase
            end
            ST_EXEC: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    pc_d    = pc_q + 1'b1;
                    wrap_d  = (pc_q == PC_MAX);
                    state_d = run ? ST_FETCH : ST_IDLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        rom_req_d     = (state_d == ST_FETCH);
        busy_d        = state_is_busy(state_d);
        halted_d      = (state_d == ST_HALT);
        ctl_clear_d   = (state_d != ST_EXEC);
        instruction_d = (state_d == ST_EXEC) ? ir_d[7:5] : OP_HALT;
        operand_d     = ir_d[4:0];
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            phase_q       <= '0;
            wait_q        <= '0;
            fault_q       <= 1'b0;
            wrap_q        <= 1'b0;
            rom_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            ctl_clear_q   <= 1'b1;
            instruction_q <= OP_HALT;
            operand_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            phase_q       <= phase_d;
            wait_q        <= wait_d;
            fault_q       <= fault_d;
            wrap_q        <= wrap_d;
            rom_req_q     <= rom_req_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            ctl_clear_q   <= ctl_clear_d;
            instruction_q <= instruction_d;
            operand_q     <= operand_d;
        end
    end

    assign pc_addr     = pc_q;
    assign rom_req     = rom_req_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign ctl_clear   = ctl_clear_q;
    assign instruction = instruction_q;
    assign operand     = operand_q;
    assign fault       = fault_q;
    assign pc_wrap     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Self-checking bench for instr_sequencer: a ROM responder,
//                an output monitor, a program-level reference model,
//                a single-step vector table and directed corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       clear_n, run, step, rom_ack;
    logic [7:0] rom_data;
    logic [4:0] pc_addr;
    logic       rom_req, ctl_clear, busy, halted, fault, pc_wrap;
    logic [2:0] instruction;
    logic [4:0] operand;

    instr_sequencer #(.PC_W(5), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .clear_n(clear_n), .run(run), .step(step),
        .pc_addr(pc_addr), .rom_req(rom_req), .rom_ack(rom_ack),
        .rom_data(rom_data), .instruction(instruction), .operand(operand),
        .ctl_clear(ctl_clear), .busy(busy), .halted(halted),
        .fault(fault), .pc_wrap(pc_wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- ROM responder ----------------
    logic [7:0] rom [32];
    bit         ack_en  = 1'b1;
    int         ack_lat = 1;
    int         lat_cnt = 0;

    initial begin
        rom_ack  = 1'b0;
        rom_data = 8'h00;
    end

    always @(negedge clk) begin
        if (rom_req && ack_en) begin
            if (lat_cnt >= ack_lat) begin
                rom_ack  = 1'b1;
                rom_data = rom[pc_addr];
            end else begin
                rom_ack = 1'b0;
                lat_cnt++;
            end
        end else begin
            rom_ack = 1'b0;
            lat_cnt = 0;
        end
    end

    // ---------------- Monitor ----------------
    typedef struct {
        logic [2:0] op;
        logic [4:0] opd;
        int         len;
    } exec_t;

    exec_t      exec_q[$];
    int         fetch_q[$];
    int         ex_len = 0;
    logic [2:0] ex_op;
    logic [4:0] ex_opd;
    int         wrap_cnt = 0;
    int         pc_unstable = 0;
    logic       prev_req = 1'b0;
    logic [4:0] prev_pc = '0;

    always @(negedge clk) begin
        if (ctl_clear === 1'b0) begin
            ex_len++;
            ex_op  = instruction;
            ex_opd = operand;
        end else if (ex_len != 0) begin
            exec_q.push_back('{ex_op, ex_opd, ex_len});
            ex_len = 0;
        end
        if (rom_req && !prev_req) fetch_q.push_back(int'(pc_addr));
        if (rom_req && prev_req && pc_addr != prev_pc) pc_unstable++;
        if (pc_wrap) wrap_cnt++;
        prev_req = rom_req;
        prev_pc  = pc_addr;
    end

    task automatic reset_dut();
        clear_n = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        ack_en  = 1'b1;
        tick();
        tick();
        clear_n = 1'b1;
        exec_q.delete();
        fetch_q.delete();
        ex_len      = 0;
        wrap_cnt    = 0;
        pc_unstable = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle_timeout"}, busy, 1'b0);
        tick();
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    // ---------------- Reference model ----------------
    int         exp_fetch[$];
    logic [2:0] exp_op[$];
    logic [4:0] exp_opd[$];
    int         exp_pc;

    // Walk the program as the architecture defines it, run held high.
    task automatic model_program();
        int         pc;
        logic [7:0] b;
        exp_fetch.delete();
        exp_op.delete();
        exp_opd.delete();
        pc = 0;
        for (int n = 0; n < 64; n++) begin
            b = rom[pc];
            exp_fetch.push_back(pc);
            if (b[7:5] == 3'b100) break;
            if (b[7:5] == 3'b101) begin
                pc = int'(b[4:0]);
            end else begin
                exp_op.push_back(b[7:5]);
                exp_opd.push_back(b[4:0]);
                pc = (pc + 1) % 32;
            end
        end
        exp_pc = pc;
    endtask

    task automatic run_program(input string tag, input int lat);
        int n = 0;
        reset_dut();
        ack_lat = lat;
        model_program();
        run = 1'b1;
        while (halted !== 1'b1 && n < 1500) begin
            tick();
            n++;
        end
        check({tag, "_halt_timeout"}, halted, 1'b1);
        run = 1'b0;
        tick();
        check({tag, "_nfetch"}, fetch_q.size(), exp_fetch.size());
        for (int i = 0; i < fetch_q.size() && i < exp_fetch.size(); i++)
            check($sformatf("%s_fetch%0d", tag, i), fetch_q[i], exp_fetch[i]);
        check({tag, "_nexec"}, exec_q.size(), exp_op.size());
        for (int i = 0; i < exec_q.size() && i < exp_op.size(); i++) begin
            check($sformatf("%s_op%0d", tag, i), exec_q[i].op, exp_op[i]);
            check($sformatf("%s_opd%0d", tag, i), exec_q[i].opd, exp_opd[i]);
            check($sformatf("%s_len%0d", tag, i), exec_q[i].len, 3);
        end
        check({tag, "_pc"}, pc_addr, exp_pc);
        check({tag, "_fault"}, fault, 1'b0);
        check({tag, "_pc_stable"}, pc_unstable, 0);
    endtask

    // ---------------- Single-step vector table ----------------
    typedef struct {
        logic [7:0] rom0;
        int         n_exec;
        logic [2:0] op;
        logic [4:0] pc;
        logic       halted;
        logic [4:0] opd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;

        vecs[0] = '{8'hE0, 1, 3'b111, 5'd1,  1'b0, 5'h00};
        vecs[1] = '{8'h00, 1, 3'b000, 5'd1,  1'b0, 5'h00};
        vecs[2] = '{8'h5F, 1, 3'b010, 5'd1,  1'b0, 5'h1F};
        vecs[3] = '{8'hC3, 1, 3'b110, 5'd1,  1'b0, 5'h03};
        vecs[4] = '{8'h80, 0, 3'b000, 5'd0,  1'b1, 5'h00};
        vecs[5] = '{8'hA9, 0, 3'b000, 5'd9,  1'b0, 5'h09};
        vecs[6] = '{8'hBF, 0, 3'b000, 5'd31, 1'b0, 5'h1F};
        vecs[7] = '{8'h9F, 0, 3'b000, 5'd0,  1'b1, 5'h1F};

        // Reset state
        reset_dut();
        check("rst_pc", pc_addr, 5'd0);
        check("rst_req", rom_req, 1'b0);
        check("rst_clr", ctl_clear, 1'b1);
        check("rst_instr", instruction, 3'b100);
        check("rst_opd", operand, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_wrap", pc_wrap, 1'b0);

        // Table: one step per vector from reset
        for (int v = 0; v < 8; v++) begin
            reset_dut();
            rom[0]  = vecs[v].rom0;
            ack_lat = 1;
            do_step();
            wait_idle($sformatf("vec%0d", v), 100);
            check($sformatf("vec%0d_nexec", v), exec_q.size(), vecs[v].n_exec);
            if (exec_q.size() > 0) begin
                check($sformatf("vec%0d_op", v), exec_q[0].op, vecs[v].op);
                check($sformatf("vec%0d_len", v), exec_q[0].len, 3);
            end
            check($sformatf("vec%0d_pc", v), pc_addr, vecs[v].pc);
            check($sformatf("vec%0d_halted", v), halted, vecs[v].halted);
            check($sformatf("vec%0d_opd", v), operand, vecs[v].opd);
            check($sformatf("vec%0d_instr", v), instruction, 3'b100);
            check($sformatf("vec%0d_clr", v), ctl_clear, 1'b1);
        end

        // Second step while busy is ignored
        reset_dut();
        rom[0] = 8'hE0;
        rom[1] = 8'h20;
        do_step();
        tick();
        tick();
        check("step_busy_mid", busy, 1'b1);
        do_step();
        wait_idle("step_busy", 100);
        repeat (5) tick();
        check("step_busy_stay_idle", busy, 1'b0);
        check("step_busy_nexec", exec_q.size(), 1);
        check("step_busy_pc", pc_addr, 5'd1);

        // Program: two executes then halt
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h60; rom[1] = 8'h20; rom[2] = 8'h80;
        run_program("prog_basic", 1);
        if (exec_q.size() >= 2) begin
            check("prog_basic_first", exec_q[0].op, 3'b011);
            check("prog_basic_second", exec_q[1].op, 3'b001);
        end
        check("prog_basic_pc2", pc_addr, 5'd2);

        // Program: jump then halt
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'hA7; rom[7] = 8'h80;
        run_program("prog_jump", 1);
        check("prog_jump_pc7", pc_addr, 5'd7);

        // PC wrap from 31 to 0
        reset_dut();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'hBF;
        do_step();
        wait_idle("wrap_jump", 100);
        check("wrap_at31", pc_addr, 5'd31);
        do_step();
        wait_idle("wrap_exec", 100);
        check("wrap_count", wrap_cnt, 1);
        check("wrap_pc0", pc_addr, 5'd0);
        check("wrap_nexec", exec_q.size(), 1);
        check("wrap_fetch31", (fetch_q.size() == 2) ? fetch_q[1] : -1, 31);

        // Fetch timeout
        reset_dut();
        ack_en = 1'b0;
        run    = 1'b1;
        begin
            int n = 0;
            while (rom_req !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
        end
        check("tmo_req_seen", rom_req, 1'b1);
        repeat (14) tick();
        check("tmo_fault_early", fault, 1'b0);
        check("tmo_req_held", rom_req, 1'b1);
        tick();
        check("tmo_fault", fault, 1'b1);
        check("tmo_halted", halted, 1'b1);
        check("tmo_req_drop", rom_req, 1'b0);
        run = 1'b0;
        repeat (3) tick();
        check("tmo_halt_sticky", halted, 1'b1);
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        check("tmo_clr_fault", fault, 1'b0);
        check("tmo_clr_halted", halted, 1'b0);
        ack_en = 1'b1;

        // Reset during execute phase 1
        reset_dut();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0]  = 8'h20;
        ack_lat = 1;
        run     = 1'b1;
        begin
            int n = 0;
            while (ctl_clear !== 1'b0 && n < 20) begin
                tick();
                n++;
            end
        end
        check("rexec_entered", ctl_clear, 1'b0);
        tick();
        check("rexec_phase1", ctl_clear, 1'b0);
        clear_n = 1'b0;
        tick();
        check("rexec_clr", ctl_clear, 1'b1);
        check("rexec_instr", instruction, 3'b100);
        check("rexec_pc", pc_addr, 5'd0);
        check("rexec_busy", busy, 1'b0);
        clear_n = 1'b1;
        run     = 1'b0;

        // Randomized forward-only programs against the model
        for (int p = 0; p < 15; p++) begin
            for (int a = 0; a < 32; a++) begin
                int r;
                r = $urandom_range(0, 19);
                if (a == 31 || r == 0) begin
                    rom[a] = {3'b100, 5'($urandom_range(0, 31))};
                end else if (r < 5) begin
                    rom[a] = {3'b101, 5'($urandom_range(a + 1, 31))};
                end else begin
                    logic [2:0] op;
                    op = 3'($urandom_range(0, 5));
                    if (op >= 3'd4) op = op + 3'd2;
                    rom[a] = {op, 5'($urandom_range(0, 31))};
                end
            end
            run_program($sformatf("rand%0d", p), $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_W, default 5, program-counter and program-address width.
REQ-002 Parameter FETCH_TIMEOUT, default 15, maximum clk cycles waiting for rom_ack.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 clear_n  in  1  reset, synchronous, active-low.
REQ-005 run  in  1  level; continuous execution enable.
REQ-006 step  in  1  single-instruction request; acts on its rising edge only.
REQ-007 pc_addr  out  PC_W  program memory address (equals PC).
REQ-008 rom_req  out  1  fetch request, held until rom_ack.
REQ-009 rom_ack  in  1  program memory data valid.
REQ-010 rom_data  in  8  instruction word: opcode [7:5], operand [4:0].
REQ-011 instruction  out  3  opcode presented to control unit.
REQ-012 operand  out  5  operand field of current instruction.
REQ-013 ctl_clear  out  1  active-high clear to control unit; low only while executing.
REQ-014 busy  out  1  high in FETCH, DECODE, EXEC.
REQ-015 halted  out  1  high in HALT state.
REQ-016 fault  out  1  sticky; fetch timeout occurred.
REQ-017 pc_wrap  out  1  one-cycle pulse when PC wraps from all-ones to 0.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, HALT.
REQ-019 IDLE: rom_req=0, ctl_clear=1, instruction=3'b100; go to FETCH on run=1 or on step rising edge.
REQ-020 run and step edge in the same cycle SHALL be treated as run; step edge discarded.
REQ-021 FETCH: rom_req=1, pc_addr stable; on rom_ack=1 capture rom_data into IR, drop rom_req next cycle, go to DECODE.
REQ-022 FETCH wait counter SHALL count cycles with rom_ack=0; reaching FETCH_TIMEOUT sets fault=1 and goes to HALT.
REQ-023 DECODE (1 cycle): opcode 3'b100 -> HALT, PC unchanged; opcode 3'b101 (JUMP) -> PC=operand (zero-extended/truncated to PC_W), then FETCH if run=1 else IDLE; any other opcode -> EXEC.
REQ-024 EXEC: ctl_clear=0, instruction=IR opcode, operand=IR operand, held stable for exactly 3 cycles (phase counter 0,1,2), matching the control unit's three-phase cycle.
REQ-025 After phase 2: PC=PC+1 modulo 2^PC_W, ctl_clear=1 next cycle; next state FETCH if run=1 else IDLE.
REQ-026 PC increment from 2^PC_W-1 to 0 SHALL assert pc_wrap for that one cycle; execution continues.
REQ-027 run falling mid-instruction SHALL let the current instruction complete, then IDLE.
REQ-028 step edges while busy=1 SHALL be ignored (no queuing).
REQ-029 Outside EXEC, instruction SHALL be 3'b100 and operand SHALL hold IR operand.
REQ-030 HALT: halted=1, ctl_clear=1, rom_req=0; exits only via clear_n.
REQ-031 Fetch-to-next-fetch latency for an executed opcode SHALL be ack cycle + 1 DECODE + 3 EXEC cycles.

Reset
REQ-032 clear_n=0 at a rising edge SHALL force: state IDLE, PC=0, IR=0, phase=0, wait counter=0, rom_req=0, ctl_clear=1, instruction=3'b100, operand=0, busy=0, halted=0, fault=0, pc_wrap=0, step-edge history=0.
REQ-033 Reset mid-EXEC or mid-FETCH SHALL abort immediately; rom_ack arriving during reset ignored.

Structure
REQ-034 Shared package SHALL hold opcode constants (HALT=3'b100, JUMP=3'b101, ALU/memory/port opcodes 3'b000-3'b011, 3'b110, 3'b111), state encoding, EXEC_CYCLES=3.
REQ-035 One sub-module, step_edge, SHALL register step and output a one-cycle rising-edge pulse.

Verification
REQ-036 Reset then run=1, ROM {0:8'h60, 1:8'h20, 2:8'h80}, ack 1 cycle after req -> instruction 3'b011 then 3'b001, each with ctl_clear=0 for 3 cycles; halted=1 with PC=2.
REQ-037 run=0, step pulse with ROM[0]=8'hE0 -> exactly one EXEC of 3'b111, PC=1, return to IDLE; second step while busy ignored.
REQ-038 ROM[0]=8'hA7 (JUMP 7), ROM[7]=8'h80 -> pc_addr 0 then 7, halted=1, PC=7.
REQ-039 PC_W=5, PC=31 executing 8'h00 -> pc_wrap pulses once, next pc_addr=0.
REQ-040 rom_ack never asserted -> fault=1 and halted=1 after 15 wait cycles; clear_n=0 clears both.
REQ-041 clear_n=0 during EXEC phase 1 -> next cycle ctl_clear=1, instruction=3'b100, PC=0, busy=0.
